// File: rtl/mod_exp_engine_pkg.sv
// Shared types and defaults for the modular-exponentiation engine.
package mod_exp_pkg;

  localparam int W_DEF     = 256;
  localparam int IDX_W_DEF = $clog2(W_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    SQR    = 3'd2,
    MUL    = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/mod_exp_engine_if.sv
// Start/done request interface between an initiator and the exponentiation engine.
interface mod_exp_engine_if
  import mod_exp_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] m;
  logic [W-1:0] result;
  logic         done;

  modport master (output start, output a, output b, output m, input result, input done);
  modport slave  (input start, input a, input b, input m, output result, output done);

endinterface

// File: rtl/mod_exp_engine_mul.sv
// Bit-serial interleaved modular multiplier: p = x*y mod m (y < m), W cycles plus a handoff cycle.
module mod_mul_serial
  import mod_exp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] m,
  output logic         rdy,
  output logic [W-1:0] p
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     r_q, r_d;
  logic [W-1:0]     xs_q, xs_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;

  // 2r + y < 3m with r,y < m, so two conditional subtractions restore r < m.
  function automatic logic [W-1:0] mac_step(input logic [W-1:0] r, input logic xb,
                                            input logic [W-1:0] yv, input logic [W-1:0] mv);
    logic [W+1:0] t;
    logic [W+1:0] mw;
    mw = {2'b00, mv};
    t  = {1'b0, r, 1'b0} + (xb ? {2'b00, yv} : '0);
    if (t >= mw) t = t - mw;
    if (t >= mw) t = t - mw;
    return t[W-1:0];
  endfunction

  always_comb begin
    r_d    = r_q;
    xs_d   = xs_q;
    y_d    = y_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    rdy_d  = rdy_q;
    if (go) begin
      // The MSB is consumed straight from the inputs on the go cycle.
      r_d    = mac_step('0, x[W-1], y, m);
      xs_d   = x << 1;
      y_d    = y;
      m_d    = m;
      cnt_d  = CNT_W'(W - 1);
      busy_d = (W > 1);
      rdy_d  = (W == 1);
    end else if (busy_q) begin
      r_d   = mac_step(r_q, xs_q[W-1], y_q, m_q);
      xs_d  = xs_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        rdy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      xs_q   <= '0;
      y_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      xs_q   <= xs_d;
      y_q    <= y_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rdy = rdy_q;
  assign p   = r_q;

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply a^b mod m over one time-shared serial multiplier.
// Define MOD_EXP_SKIP_LZ_EN to start the scan at the highest set exponent bit.
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mod_exp_engine_if.slave  bus
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     base_q, base_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic             issued_q, issued_d;
  logic             done_q, done_d;

  logic             mul_go;
  logic [W-1:0]     mul_x;
  logic [W-1:0]     mul_y;
  logic             mul_rdy;
  logic [W-1:0]     mul_p;

`ifdef MOD_EXP_SKIP_LZ_EN
  function automatic logic [IDX_W-1:0] msb_idx(input logic [W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < W; k++) begin
      if (v[k]) idx = IDX_W'(k);
    end
    return idx;
  endfunction
`endif

  mod_mul_serial #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .go    (mul_go),
    .x     (mul_x),
    .y     (mul_y),
    .m     (m_q),
    .rdy   (mul_rdy),
    .p     (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    base_d   = base_q;
    acc_d    = acc_q;
    result_d = result_q;
    i_d      = i_q;
    issued_d = issued_q;
    done_d   = done_q;
    mul_go   = 1'b0;
    mul_x    = acc_q;
    mul_y    = acc_q;

    case (state_q)
      IDLE, FINISH: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          m_d      = bus.m;
          done_d   = 1'b0;
          issued_d = 1'b0;
          if (bus.m <= W'(1)) begin
            acc_d   = '0;
            state_d = FINISH;
          end else begin
            state_d = REDUCE;
          end
        end else if (state_q == FINISH) begin
          // done is registered together with result, so it never leads the data.
          result_d = acc_q;
          done_d   = 1'b1;
        end
      end
      REDUCE: begin
        mul_x = a_q;
        mul_y = W'(1);
        if (!issued_q) begin
          mul_go   = 1'b1;
          issued_d = 1'b1;
        end else if (mul_rdy) begin
          issued_d = 1'b0;
          base_d   = mul_p;
          acc_d    = W'(1);
`ifdef MOD_EXP_SKIP_LZ_EN
          if (b_q == '0) begin
            state_d = FINISH;
          end else begin
            i_d     = msb_idx(b_q);
            state_d = SQR;
          end
`else
          i_d     = IDX_W'(W - 1);
          state_d = SQR;
`endif
        end
      end
      SQR: begin
        if (!issued_q) begin
          mul_go   = 1'b1;
          issued_d = 1'b1;
        end else if (mul_rdy) begin
          issued_d = 1'b0;
          acc_d    = mul_p;
          state_d  = b_q[i_q] ? MUL : NEXT;
        end
      end
      MUL: begin
        mul_y = base_q;
        if (!issued_q) begin
          mul_go   = 1'b1;
          issued_d = 1'b1;
        end else if (mul_rdy) begin
          issued_d = 1'b0;
          acc_d    = mul_p;
          state_d  = NEXT;
        end
      end
      NEXT: begin
        if (i_q == '0) begin
          state_d = FINISH;
        end else begin
          i_d     = i_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      i_q      <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      i_q      <= i_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at W=32: result values, start-to-done latency, handshake corners.
module tb_mod_exp_engine;

  localparam int W     = 32;
  localparam int LIMIT = 5000;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] res;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mod_exp_engine_if #(.W(W)) bus_if ();

  mod_exp_engine #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b, input logic [W-1:0] m);
    int nb;
    if (m <= 1) return 2;
`ifdef MOD_EXP_SKIP_LZ_EN
    if (b == 0) return 2 + (W + 1);
    nb = 0;
    for (int k = 0; k < W; k++) if (b[k]) nb = k + 1;
`else
    nb = W;
`endif
    return 2 + (W + 1) * (1 + nb + $countones(b)) + nb;
  endfunction

  // Pulses start, scrambles the operand inputs afterwards, optionally fires a
  // stray start (2,3,7) at cycle inj, and counts cycles until done.
  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                         input int inj, output logic [W-1:0] res, output int lat,
                         output logic done_low);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = a;
    bus_if.b = b;
    bus_if.m = m;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a = ~a;
    bus_if.b = ~b;
    bus_if.m = ~m;
    done_low = !bus_if.done;
    lat = 1;
    while (!bus_if.done && lat < LIMIT) begin
      if (lat == inj) begin
        bus_if.start = 1'b1;
        bus_if.a = 2;
        bus_if.b = 3;
        bus_if.m = 7;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus_if.start = 1'b0;
    res = bus_if.result;
  endtask

  vec_t         vecs[12];
  logic [W-1:0] res;
  int           lat;
  logic         dlow;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{32'd1,          32'd2,          32'd5,          32'd1};
    vecs[1]  = '{32'd7,          32'd5,          32'd13,         32'd11};
    vecs[2]  = '{32'd5,          32'd0,          32'd13,         32'd1};
    vecs[3]  = '{32'd20,         32'd1,          32'd13,         32'd7};
    vecs[4]  = '{32'd4,          32'd9,          32'd1,          32'd0};
    vecs[5]  = '{32'd4,          32'd9,          32'd0,          32'd0};
    vecs[6]  = '{32'd0,          32'd5,          32'd7,          32'd0};
    vecs[7]  = '{32'd100,        32'd2,          32'd7,          32'd4};
    vecs[8]  = '{32'd2,          32'd10,         32'd1000,       32'd24};
    vecs[9]  = '{32'hFFFFFFFF,   32'd2,          32'hFFFFFFFB,   32'd16};
    vecs[10] = '{32'hFFFFFFF0,   32'hFFFFFFFF,   32'hFFFFFFF1,   32'hFFFFFFF0};
    vecs[11] = '{32'd3,          32'd4,          32'd7,          32'd4};

    reset = 1'b0;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    bus_if.m = '0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'b0, bus_if.done}, 32'd0);
    check("reset_result", bus_if.result, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_job(vecs[i].a, vecs[i].b, vecs[i].m, 0, res, lat, dlow);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), W'(lat), W'(exp_lat(vecs[i].b, vecs[i].m)));
      check($sformatf("vec%0d_done_fell", i), {31'b0, dlow}, 32'd1);
    end

    repeat (5) @(negedge clk);
    check("hold_done", {31'b0, bus_if.done}, 32'd1);
    check("hold_result", bus_if.result, 32'd4);

    // Back-to-back identical jobs; the second sees a stray start mid-run.
    run_job(32'd9081235, 32'd3728103, 32'd98234125, 0, res, lat, dlow);
    check("b2b1_result", res, 32'd23831250);
    check("b2b1_latency", W'(lat), W'(exp_lat(32'd3728103, 32'd98234125)));
    run_job(32'd9081235, 32'd3728103, 32'd98234125, 100, res, lat, dlow);
    check("b2b2_done_fell", {31'b0, dlow}, 32'd1);
    check("b2b2_result", res, 32'd23831250);
    check("b2b2_latency", W'(lat), W'(exp_lat(32'd3728103, 32'd98234125)));

    // Asynchronous reset while the engine is squaring.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.a = 32'd9081235;
    bus_if.b = 32'd3728103;
    bus_if.m = 32'd98234125;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (W + 10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_done", {31'b0, bus_if.done}, 32'd0);
    check("abort_result", bus_if.result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_job(32'd3, 32'd4, 32'd7, 0, res, lat, dlow);
    check("post_reset_result", res, 32'd4);
    check("post_reset_latency", W'(lat), W'(exp_lat(32'd4, 32'd7)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
